// File: rtl/plru_refill_ctrl.sv
// Miss-to-refill controller that picks a PLRU/free victim, runs the refill handshake and reports the fill back to the PLRU.
// Optional refill watchdog enabled by defining PLRU_REFILL_TIMEOUT_EN.
module plru_refill_ctrl #(
    parameter int ENTRY_COUNT    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_valid_i,
    output logic                   miss_ready_o,
    input  logic [ADDR_WIDTH-1:0]  miss_addr_i,
    input  logic [ENTRY_COUNT-1:0] victim_mask_i,
    input  logic [ENTRY_COUNT-1:0] valid_mask_i,
    input  logic [ENTRY_COUNT-1:0] hit_mask_i,
    output logic                   refill_req_valid_o,
    input  logic                   refill_req_ready_i,
    output logic [ADDR_WIDTH-1:0]  refill_req_addr_o,
    input  logic                   refill_resp_valid_i,
    input  logic                   refill_resp_err_i,
    output logic                   fill_we_o,
    output logic [ENTRY_COUNT-1:0] fill_way_mask_o,
    output logic [ENTRY_COUNT-1:0] access_mask_o,
    output logic                   done_valid_o,
    output logic                   done_err_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } state_t;

    if (ENTRY_COUNT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("plru_refill_ctrl: ENTRY_COUNT and TIMEOUT_CYCLES must be >= 1");
    end

    // Free entry wins; otherwise lowest PLRU candidate; entry 0 when the PLRU offers nothing.
    function automatic logic [ENTRY_COUNT-1:0] pick_victim(
        input logic [ENTRY_COUNT-1:0] valid_mask,
        input logic [ENTRY_COUNT-1:0] victim_mask
    );
        logic [ENTRY_COUNT-1:0] pick;
        pick    = '0;
        pick[0] = 1'b1;
        for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
            if (victim_mask[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
        for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
            if (!valid_mask[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
        return pick;
    endfunction

    state_t                 state_r, state_s;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [ENTRY_COUNT-1:0] way_r;
    logic                   fill_we_r, fill_we_s;
    logic                   done_valid_r, done_valid_s;
    logic                   done_err_r, done_err_s;

`ifdef PLRU_REFILL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_r, cnt_s;

    // Watchdog counter, cleared on the way into WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_s;
        end
    end
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_s      = state_r;
        fill_we_s    = 1'b0;
        done_valid_s = 1'b0;
        done_err_s   = 1'b0;
`ifdef PLRU_REFILL_TIMEOUT_EN
        cnt_s        = cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (miss_valid_i) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
`ifdef PLRU_REFILL_TIMEOUT_EN
                cnt_s = '0;
`endif
                if (refill_req_ready_i) begin
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (refill_resp_valid_i && refill_resp_err_i) begin
                    state_s      = IDLE;
                    done_valid_s = 1'b1;
                    done_err_s   = 1'b1;
                end else if (refill_resp_valid_i) begin
                    state_s      = FILL;
                    fill_we_s    = 1'b1;
                    done_valid_s = 1'b1;
                end else begin
`ifdef PLRU_REFILL_TIMEOUT_EN
                    if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_s      = IDLE;
                        done_valid_s = 1'b1;
                        done_err_s   = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
`else
                    state_s = WAIT;
`endif
                end
            end
            FILL: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and completion-strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            fill_we_r    <= 1'b0;
            done_valid_r <= 1'b0;
            done_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            fill_we_r    <= fill_we_s;
            done_valid_r <= done_valid_s;
            done_err_r   <= done_err_s;
        end
    end

    // Address and victim are captured once at accept and held until the next miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= '0;
            way_r  <= '0;
        end else if (state_r == IDLE && miss_valid_i) begin
            addr_r <= miss_addr_i;
            way_r  <= pick_victim(valid_mask_i, victim_mask_i);
        end else begin
            addr_r <= addr_r;
            way_r  <= way_r;
        end
    end

    assign miss_ready_o       = (state_r == IDLE);
    assign refill_req_valid_o = (state_r == REQ);
    assign refill_req_addr_o  = addr_r;
    assign fill_we_o          = fill_we_r;
    assign fill_way_mask_o    = way_r;
    assign access_mask_o      = hit_mask_i | (fill_we_r ? way_r : {ENTRY_COUNT{1'b0}});
    assign done_valid_o       = done_valid_r;
    assign done_err_o         = done_err_r;
    assign busy_o             = (state_r != IDLE);

endmodule

// File: tb/tb_plru_refill_ctrl.sv
// Scoreboard bench for plru_refill_ctrl: directed misses push expected completions, a negedge monitor checks them.
module tb_plru_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_valid = 1'b0;
    logic        miss_ready;
    logic [31:0] miss_addr = 32'h0;
    logic [3:0]  victim_mask = 4'b0000;
    logic [3:0]  valid_mask = 4'b0000;
    logic [3:0]  hit_mask = 4'b0000;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic        resp_err = 1'b0;
    logic        fill_we;
    logic [3:0]  fill_way_mask;
    logic [3:0]  access_mask;
    logic        done_valid;
    logic        done_err;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] way;
        logic       err;
        logic [3:0] hit;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    plru_refill_ctrl #(
        .ENTRY_COUNT(4),
        .ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .miss_valid_i(miss_valid),
        .miss_ready_o(miss_ready),
        .miss_addr_i(miss_addr),
        .victim_mask_i(victim_mask),
        .valid_mask_i(valid_mask),
        .hit_mask_i(hit_mask),
        .refill_req_valid_o(req_valid),
        .refill_req_ready_i(req_ready),
        .refill_req_addr_o(req_addr),
        .refill_resp_valid_i(resp_valid),
        .refill_resp_err_i(resp_err),
        .fill_we_o(fill_we),
        .fill_way_mask_o(fill_way_mask),
        .access_mask_o(access_mask),
        .done_valid_o(done_valid),
        .done_err_o(done_err),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", done_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("done_err", done_err, e.err);
                    chk("fill_we", fill_we, !e.err);
                    chk("fill_way_mask", fill_way_mask, e.way);
                    chk("access_mask", access_mask, e.err ? e.hit : (e.hit | e.way));
                    chk("done_cycle", cyc, e.cyc);
                end
            end else if (fill_we) begin
                chk("stray_fill_we", fill_we, 1'b0);
            end
        end
    end

    task automatic do_miss(input logic [31:0] addr, input logic [3:0] vmask, input logic [3:0] victim,
                           input int stall, input logic err, input logic [3:0] hit_fill,
                           input logic [3:0] exp_way);
        exp_t e;
        miss_valid  = 1'b1;
        miss_addr   = addr;
        valid_mask  = vmask;
        victim_mask = victim;
        chk("miss_ready_idle", miss_ready, 1'b1);
        e.way = exp_way;
        e.err = err;
        e.hit = hit_fill;
        e.cyc = cyc + 3 + stall;
        sb.push_back(e);
        step();
        miss_valid  = 1'b0;
        miss_addr   = ~addr;
        valid_mask  = 4'b0000;
        victim_mask = 4'b1111;
        for (int i = 0; i <= stall; i++) begin
            chk("req_valid", req_valid, 1'b1);
            chk("req_addr", req_addr, addr);
            chk("way_stable", fill_way_mask, exp_way);
            req_ready = (i == stall);
            step();
        end
        req_ready = 1'b0;
        chk("req_valid_wait", req_valid, 1'b0);
        resp_valid = 1'b1;
        resp_err   = err;
        step();
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        hit_mask   = hit_fill;
        chk("miss_ready_after_resp", miss_ready, err);
        step();
        hit_mask = 4'b0000;
    endtask

    initial begin
        exp_t e;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done_valid, 1'b0);
        chk("rst_fill_we", fill_we, 1'b0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_way_mask", fill_way_mask, 4'b0000);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_miss_ready", miss_ready, 1'b1);
        rst = 1'b0;
        step();

        do_miss(32'h0000_1000, 4'b1011, 4'b0001, 0, 1'b0, 4'b0000, 4'b0100);
        do_miss(32'h0000_2000, 4'b1111, 4'b1000, 3, 1'b0, 4'b0000, 4'b1000);
        do_miss(32'h0000_3000, 4'b1111, 4'b0010, 0, 1'b1, 4'b0100, 4'b0010);
        do_miss(32'h0000_3004, 4'b1111, 4'b1000, 1, 1'b0, 4'b0010, 4'b1000);
        do_miss(32'hDEAD_BEE0, 4'b1111, 4'b0000, 0, 1'b0, 4'b0000, 4'b0001);
        do_miss(32'h1234_5670, 4'b1111, 4'b0110, 2, 1'b0, 4'b0001, 4'b0010);
        do_miss(32'hFFFF_FFC0, 4'b0110, 4'b1000, 0, 1'b0, 4'b0000, 4'b0001);

        // Reset while waiting for a refill, then a stale response must be ignored.
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_4000;
        valid_mask = 4'b1111;
        victim_mask = 4'b0100;
        step();
        miss_valid = 1'b0;
        req_ready  = 1'b1;
        step();
        req_ready = 1'b0;
        chk("busy_in_wait", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        resp_valid = 1'b1;
        step();
        resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stale_busy", busy, 1'b0);
            chk("stale_fill_we", fill_we, 1'b0);
            chk("stale_done", done_valid, 1'b0);
            step();
        end

        // Refill that never answers.
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_5000;
        victim_mask = 4'b0010;
        step();
        miss_valid = 1'b0;
        req_ready  = 1'b1;
`ifdef PLRU_REFILL_TIMEOUT_EN
        e.way = 4'b0010;
        e.err = 1'b1;
        e.hit = 4'b0000;
        e.cyc = cyc + 1 + 8;
        sb.push_back(e);
        step();
        req_ready = 1'b0;
        repeat (12) step();
        chk("timeout_idle", busy, 1'b0);
`else
        step();
        req_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            chk("no_timeout_busy", busy, 1'b1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`endif

        repeat (3) step();
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
